// File: rtl/debounce_array.sv
// Multi-channel pushbutton debouncer: two-flop synchroniser, stability filter,
// and registered press / release / long-press event pulses per channel.
module debounce_array #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);

  // Pin value that reads as "not pressed"; sync flops idle here after reset.
  localparam logic [CHANNELS-1:0] IDLE_PINS = (ACTIVE_HIGH != 0) ? '0 : '1;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] raw;

  logic [SW-1:0] stab_cnt [CHANNELS];
  logic [HW-1:0] hold_cnt [CHANNELS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two-stage synchroniser a pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE_PINS;
      sync2 <= IDLE_PINS;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign raw = (ACTIVE_HIGH != 0) ? sync2 : ~sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level      <= '0;
      press      <= '0;
      released   <= '0;
      long_press <= '0;
      // NOTE: the counter arrays are ordinary flops, not RAM, so they take the
      // async reset; a reset mid-count must drop any partial progress.
      for (int i = 0; i < CHANNELS; i++) begin
        stab_cnt[i] <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      press      <= '0;
      released   <= '0;
      long_press <= '0;

      for (int i = 0; i < CHANNELS; i++) begin
        // Stability filter: any return to the current level restarts the count.
        if (raw[i] == level[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == STABLE_LAST) begin
          stab_cnt[i] <= '0;
          level[i]    <= raw[i];
          press[i]    <= raw[i];
          released[i] <= ~raw[i];
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 1'b1;
        end

        // Hold timer saturates so long_press fires once per press.
        if (!level[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          if (hold_cnt[i] == LONG_LAST) begin
            long_press[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: one active-high instance for the main
// behaviour and one active-low instance for pin polarity.
module tb_debounce_array;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] level, press, released, long_press;
  logic [3:0] btn_n;
  logic [3:0] level_n, press_n, released_n, long_press_n;

  int checks   = 0;
  int failures = 0;

  logic [3:0] acc_press, acc_rel, acc_long, acc_level, acc_press_n;

  debounce_array #(
    .CHANNELS(4), .STABLE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .level(level), .press(press), .released(released), .long_press(long_press)
  );

  debounce_array #(
    .CHANNELS(4), .STABLE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_HIGH(0)
  ) dut_n (
    .clk(clk), .rst(rst), .btn(btn_n),
    .level(level_n), .press(press_n), .released(released_n), .long_press(long_press_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    acc_press   = '0;
    acc_rel     = '0;
    acc_long    = '0;
    acc_level   = '0;
    acc_press_n = '0;
  endtask

  // Advance n falling edges, folding every sampled output into the accumulators.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      acc_press   |= press;
      acc_rel     |= released;
      acc_long    |= long_press;
      acc_level   |= level;
      acc_press_n |= press_n;
    end
  endtask

  logic [11:0] bounce_pat;

  initial begin
    rst   = 1'b0;
    btn   = 4'b0000;
    btn_n = 4'b1111;
    clr();
    tick(2);
    check("rst_level",   level,      4'b0000);
    check("rst_press",   press,      4'b0000);
    check("rst_release", released,   4'b0000);
    check("rst_long",    long_press, 4'b0000);
    check("rst_level_n", level_n,    4'b0000);

    rst = 1'b1;
    clr();
    tick(10);
    check("idle_press",   acc_press,   4'b0000);
    check("idle_press_n", acc_press_n, 4'b0000);
    check("idle_level_n", level_n,     4'b0000);

    // Active-low polarity: pin dropping is a press.
    btn_n[0] = 1'b0;
    tick(5);
    check("pol_early", press_n, 4'b0000);
    tick(1);
    check("pol_press", press_n, 4'b0001);
    check("pol_level", level_n, 4'b0001);
    btn_n[0] = 1'b1;
    tick(8);
    check("pol_relvl", level_n, 4'b0000);

    // Clean press and release on channel 0.
    clr();
    btn[0] = 1'b1;
    tick(5);
    check("clean_early_lvl", level,     4'b0000);
    check("clean_early_prs", acc_press, 4'b0000);
    tick(1);
    check("clean_press", press, 4'b0001);
    check("clean_level", level, 4'b0001);
    tick(1);
    check("clean_press_gone", press, 4'b0000);
    check("clean_level_hold", level, 4'b0001);
    btn[0] = 1'b0;
    tick(5);
    check("clean_rel_early", level, 4'b0001);
    tick(1);
    check("clean_release", released, 4'b0001);
    check("clean_rel_lvl",  level,    4'b0000);
    tick(1);
    check("clean_rel_gone", released, 4'b0000);
    check("clean_no_long",  acc_long, 4'b0000);

    // Bounce on channel 1: runs of 1-3 cycles never reach the threshold.
    clr();
    bounce_pat = 12'b1110_1100_1110;
    for (int i = 11; i >= 0; i--) begin
      btn[1] = bounce_pat[i];
      tick(1);
    end
    btn[1] = 1'b1;
    check("bounce_no_press", acc_press, 4'b0000);
    tick(5);
    check("bounce_early", acc_press, 4'b0000);
    tick(1);
    check("bounce_press", press, 4'b0010);
    tick(1);
    check("bounce_single", press, 4'b0000);
    btn[1] = 1'b0;
    tick(6);
    check("bounce_release", released, 4'b0010);
    tick(2);

    // Isolated 3-cycle glitch.
    clr();
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(10);
    check("glitch_press", acc_press, 4'b0000);
    check("glitch_level", acc_level, 4'b0000);

    // Long press on channel 2, pin held for 40 cycles.
    clr();
    btn[2] = 1'b1;
    tick(6);
    check("long_press_evt", press, 4'b0100);
    clr();
    tick(19);
    check("long_early", acc_long, 4'b0000);
    tick(1);
    check("long_fire", long_press, 4'b0100);
    clr();
    tick(1);
    check("long_gone", long_press, 4'b0000);
    tick(13);
    btn[2] = 1'b0;
    tick(5);
    check("long_rel_early", level, 4'b0100);
    tick(1);
    check("long_release", released, 4'b0100);
    tick(5);
    check("long_once",   acc_long,  4'b0000);
    check("press_once",  acc_press, 4'b0000);

    // Short hold: released well before the long threshold.
    btn[2] = 1'b1;
    tick(6);
    check("short_press", press, 4'b0100);
    clr();
    tick(4);
    btn[2] = 1'b0;
    tick(6);
    check("short_release", released, 4'b0100);
    tick(20);
    check("short_no_long", acc_long, 4'b0000);

    // All channels together, then a partial release.
    clr();
    btn = 4'b1111;
    tick(5);
    check("multi_early", acc_press, 4'b0000);
    tick(1);
    check("multi_press", press, 4'b1111);
    tick(1);
    check("multi_press_gone", press, 4'b0000);
    btn = 4'b0101;
    tick(5);
    clr();
    tick(1);
    check("multi_release", released, 4'b1010);
    check("multi_level",   level,    4'b0101);
    check("multi_no_press", press,   4'b0000);
    tick(1);
    check("multi_rel_gone", released, 4'b0000);
    btn = 4'b0000;
    tick(6);
    check("multi_release2", released, 4'b0101);
    check("multi_level0",   level,    4'b0000);
    check("multi_no_long",  acc_long, 4'b0000);
    tick(2);

    // Reset mid-hold: channel 0 pressed, hold counter at 10.
    btn[0] = 1'b1;
    tick(6);
    check("mid_press", press, 4'b0001);
    tick(10);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_level", level,      4'b0000);
    check("mid_rst_press", press,      4'b0000);
    check("mid_rst_long",  long_press, 4'b0000);
    tick(1);
    rst = 1'b1;
    clr();
    tick(5);
    check("mid_early", acc_press, 4'b0000);
    check("mid_early_lvl", acc_level, 4'b0000);
    tick(1);
    check("mid_repress", press, 4'b0001);
    tick(19);
    check("mid_long_early", acc_long, 4'b0000);
    tick(1);
    check("mid_long", long_press, 4'b0001);
    btn[0] = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Each channel synchronises one raw pushbutton or switch pin and filters out bounce with a stability counter.
- Each channel reports a clean debounced level plus one-cycle press, release and long-press event pulses.
- Sits between board I/O pins and user logic (menu FSMs, mode toggles) on the iCE40 designs.

Parameters:
- CHANNELS, 4: number of independent input channels, >= 1.
- STABLE_CYCLES, 16: consecutive cycles raw input must differ from current level before level changes, >= 1.
- LONG_CYCLES, 1000: cycles level must stay 1 after a press before long_press fires, >= 1.
- ACTIVE_HIGH, 1: 1 = pin high means pressed; 0 = pin low means pressed (inverted after sync).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- btn  input  CHANNELS  raw asynchronous button pins, one bit per channel.
- level  output  CHANNELS  debounced state, 1 = pressed.
- press  output  CHANNELS  one-cycle pulse when level goes 0->1.
- release  output  CHANNELS  one-cycle pulse when level goes 1->0.
- long_press  output  CHANNELS  one-cycle pulse when level has been 1 for LONG_CYCLES cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops load the pin's inactive value (0 if ACTIVE_HIGH, else 1).
  - all counters clear.
  - level, press, release and long_press are 0.
  - rst deassertion is synchronised to clk upstream.
- Synchroniser: two flops per channel. raw = ACTIVE_HIGH ? sync2 : ~sync2.
- Stability counter:
  - Width $clog2(STABLE_CYCLES+1), one per channel.
  - On each rising edge, if raw == level, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter would reach STABLE_CYCLES: level <= raw and counter <= 0.
- Latency: a pin stable from before edge k gives an updated level visible after edge k+STABLE_CYCLES+1.
- Glitch rejection: any bounce that returns raw to the current level before STABLE_CYCLES consecutive mismatches resets the counter. Level, press and release do not change.
- Events:
  - press and release are registered and asserted in the same cycle that level changes.
  - Each is exactly 1 cycle wide.
  - press and release are mutually exclusive per channel.
- Hold counter:
  - Width $clog2(LONG_CYCLES+1), one per channel.
  - Clears while level=0.
  - Increments each edge while level=1, saturating at LONG_CYCLES.
  - long_press pulses for 1 cycle on the edge where the hold counter reaches LONG_CYCLES, i.e. after edge P+LONG_CYCLES, where P is the edge that set level=1.
  - Only one long_press per press; no auto-repeat.
  - Release before LONG_CYCLES: no long_press.
  - Release after long_press: release still pulses normally.
- Channels are fully independent. Simultaneous events on several channels assert their respective bits in the same cycle.
- Reset mid-operation:
  - All state clears immediately, including in-flight pulses and partial counts.
  - A button held through reset reads as a new press STABLE_CYCLES+2 edges after rst deasserts.
- No combinational path from btn to any output.

Test Plan (bench overrides: CHANNELS=4, STABLE_CYCLES=4, LONG_CYCLES=20, ACTIVE_HIGH=1):
- Clean press:
  - Stimulus: btn[0] 0->1 before edge k, then held.
  - Response: level[0]=1 and press[0]=1 after edge k+5; press[0]=0 after edge k+6; other channels 0.
- Bounce rejection:
  - Stimulus: btn[1] toggles every 1-3 cycles for 12 cycles, then settles at 1.
  - Response: no press[1] during the bounce; a single press[1] exactly 5 edges after settling.
  - Stimulus: a 3-cycle high glitch alone.
  - Response: no output.
- Long press:
  - Stimulus: hold btn[2] for 40 cycles.
  - Response: press[2] once; long_press[2] exactly 20 cycles after press[2] and only once; release[2] 5 edges after the pin drops.
  - Stimulus: hold for 10 cycles.
  - Response: no long_press.
- Multi-channel simultaneity:
  - Stimulus: btn[3:0] 0000->1111 on the same edge.
  - Response: press=1111 on a single cycle.
  - Stimulus: btn[3:0] 1111->0101.
  - Response: release=1010 on one cycle; level=0101.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (mid-cycle) while level[0]=1 and the hold counter is at 10; keep btn[0]=1; deassert.
  - Response: outputs 0 immediately; press[0] STABLE_CYCLES+2 edges after deassert; long_press[0] 20 cycles later.
- Polarity (ACTIVE_HIGH=0):
  - Stimulus: btn idle at 1; btn[0] 1->0.
  - Response: after reset, level=0 with no spurious press; press[0] after 5 edges.
